branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, feeding the IF stage.
//  Lookup is combinational on the fetch PC and produces the predicted jump flag and target; the jump flag drives the controller's jump input.
//  Resolution comes back from the ID-stage controller (branch, taken, target, flush) and updates the table on the clock edge.
//  Also keeps lookup and mispredict counters for performance measurement.
// PARAMETERS
//  ADDR_W   32  PC and target width
//  INDEX_W  4   index bits; ENTRIES = 2**INDEX_W = 16
//  CNT_W    32  width of the performance counters
// PORTS
//  clk           in   1                 system clock; all state updates on rising edge
//  rst           in   1                 synchronous, active-high reset
//  btb_en        in   1                 prediction enable; 0 forces pred_jump=0 (updates still accepted)
//  if_pc         in   ADDR_W            fetch PC being looked up this cycle
//  pred_jump     out  1                 predict taken: hit & counter[1] & btb_en
//  pred_target   out  ADDR_W            stored target on hit, else if_pc+4
//  upd_valid     in   1                 resolved control-transfer instr in ID (controller branch=1)
//  upd_pc        in   ADDR_W            PC of resolved instr
//  upd_taken     in   1                 actual outcome (controller pcsrc!=0)
//  upd_target    in   ADDR_W            actual target
//  upd_mispred   in   1                 controller IF_flash for this instr
//  btb_clear     in   1                 invalidate whole table next edge
//  lookup_cnt    out  CNT_W             cycles with btb_en=1
//  mispred_cnt   out  CNT_W             cycles with upd_valid&upd_mispred
// BEHAVIOUR
//  Address split: idx = pc[INDEX_W+1:2], tag = pc[ADDR_W-1:INDEX_W+2]; pc[1:0] ignored.
//  Entry = {valid, tag, target, ctr[1:0]}; ctr encodings 00 SNT, 01 WNT, 10 WT, 11 ST.
//  Lookup (combinational, 0 latency):
//   - hit = valid[idx] & tag match.
//   - No bypass: an update in the same cycle is visible only from the next cycle.
//  Update (on edge when upd_valid=1 and no rst/btb_clear), at the entry selected by upd_pc:
//   - Hit, taken: ctr saturating +1 (11 stays 11); target <= upd_target.
//   - Hit, not taken: ctr saturating -1 (00 stays 00); target unchanged.
//   - Miss, taken: allocate/replace (valid=1, new tag, target, ctr=10).
//   - Miss, not taken: no change.
//  Precedence: rst > btb_clear > update.
//   - btb_clear clears all valid bits only; tags, targets and counters are kept.
//  Reset (rst=1 at edge, also mid-operation):
//   - all valid <= 0, all ctr <= 01, lookup_cnt <= 0, mispred_cnt <= 0.
//   - Outputs after reset: pred_jump=0, pred_target=if_pc+4.
//  Counters: +1 per qualifying cycle; wrap modulo 2**CNT_W with no saturation.
//  Target arithmetic: if_pc+4 is ADDR_W bits; carry out is discarded (FFFFFFFC -> 00000000).
//  Aliasing: two PCs with equal idx evict each other. Stale tag/target contents are never used while valid=0.
// TESTING
//  1 Reset, if_pc=0x100, btb_en=1 -> pred_jump=0, pred_target=0x104, both counters 0.
//  2 upd pc=0x100 taken tgt=0x200 -> next cycle lookup 0x100 gives pred_jump=1, target 0x200 (ctr=10).
//  3 Entry of test 2, then two not-taken updates -> ctr 01 then 00, pred_jump=0, target still 0x200; a third update stays 00.
//  4 Alias: taken 0x100->0x200, then taken 0x140->0x300 (same idx) -> lookup 0x100 misses (target 0x104); 0x140 hits with 0x300.
//  5 Lookup and update on the same idx in the same cycle -> lookup shows the old entry; btb_clear together with upd_valid -> table empty next cycle.
//  6 Preload mispred_cnt near 2**CNT_W-1 (or CNT_W=4): 16 mispredicts wrap to 0; btb_en=0 -> pred_jump=0 and lookup_cnt frozen.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters for the IF stage.
// Lookup is combinational on the fetch PC; resolutions from ID update the table on the clock edge.
module branch_target_predictor #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btb_en,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_jump,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  input  logic              btb_clear,
  output logic [CNT_W-1:0]  lookup_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int unsigned ENTRIES = 2 ** INDEX_W;
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - 2;
  localparam int unsigned IDX_LO  = 2;
  localparam int unsigned TAG_LO  = INDEX_W + 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic [ADDR_W-1:0]  lk_seq_pc;

  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  logic [1:0]         up_ctr_inc;
  logic [1:0]         up_ctr_dec;

  // Byte offset bits never select an entry or form part of a tag
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == CTR_ST) ? CTR_ST : 2'(c + 2'd1);
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == CTR_SNT) ? CTR_SNT : 2'(c - 2'd1);
  endfunction

  // Fetch-side lookup; sees only state committed at earlier edges
  always_comb begin
    lk_idx    = if_pc[INDEX_W+1:IDX_LO];
    lk_tag    = if_pc[ADDR_W-1:TAG_LO];
    lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_seq_pc = ADDR_W'(if_pc + ADDR_W'(4));
  end

  assign pred_jump   = btb_en && lk_hit && ctr_q[lk_idx][1];
  assign pred_target = lk_hit ? target_q[lk_idx] : lk_seq_pc;

  // Resolution-side decode of the entry addressed by the resolved instruction
  always_comb begin
    up_idx     = upd_pc[INDEX_W+1:IDX_LO];
    up_tag     = upd_pc[ADDR_W-1:TAG_LO];
    up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr_inc = ctr_inc(ctr_q[up_idx]);
    up_ctr_dec = ctr_dec(ctr_q[up_idx]);
  end

  // Valid bits and counters: reset wins over clear, clear wins over update
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (btb_clear) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= upd_taken ? up_ctr_inc : up_ctr_dec;
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_WT;
      end
    end
  end

  // Tag/target payload is only meaningful while valid, so it carries no reset
  always_ff @(posedge clk) begin
    if (!rst && !btb_clear && upd_valid && upd_taken) begin
      if (!up_hit) begin
        tag_q[up_idx] <= up_tag;
      end
      target_q[up_idx] <= upd_target;
    end
  end

  // Performance counters wrap freely
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (btb_en) begin
        lookup_cnt <= CNT_W'(lookup_cnt + CNT_W'(1));
      end
      if (upd_valid && upd_mispred) begin
        mispred_cnt <= CNT_W'(mispred_cnt + CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        btb_en;
  logic [31:0] if_pc;
  logic        pred_jump;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        btb_clear;
  logic [3:0]  lookup_cnt;
  logic [3:0]  mispred_cnt;

  branch_target_predictor #(.ADDR_W(32), .INDEX_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .btb_en(btb_en), .if_pc(if_pc),
    .pred_jump(pred_jump), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .btb_clear(btb_clear),
    .lookup_cnt(lookup_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pj;
    logic [31:0] pt;
    logic [3:0]  lc;
    logic [3:0]  mc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] lc_m = '0;
  logic [3:0] mc_m = '0;

  // Monitor: compare whatever expectation is pending, mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (pred_jump !== e.pj) begin
        bad++;
        $display("FAIL %s pred_jump: got %0b want %0b", e.name, pred_jump, e.pj);
      end
      total++;
      if (pred_target !== e.pt) begin
        bad++;
        $display("FAIL %s pred_target: got %h want %h", e.name, pred_target, e.pt);
      end
      total++;
      if (lookup_cnt !== e.lc) begin
        bad++;
        $display("FAIL %s lookup_cnt: got %0d want %0d", e.name, lookup_cnt, e.lc);
      end
      total++;
      if (mispred_cnt !== e.mc) begin
        bad++;
        $display("FAIL %s mispred_cnt: got %0d want %0d", e.name, mispred_cnt, e.mc);
      end
    end
  end

  // Counter expectations: count qualifying cycles, wrapping at 16
  task automatic tick();
    if (rst) begin
      lc_m = '0;
      mc_m = '0;
    end else begin
      lc_m = lc_m + 4'(btb_en);
      if (upd_valid && upd_mispred) mc_m = mc_m + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic pj, input logic [31:0] pt);
    exp_t x;
    x.name = name; x.pj = pj; x.pt = pt; x.lc = lc_m; x.mc = mc_m;
    sb.push_back(x);
  endtask

  task automatic upd(input logic v, input logic [31:0] pc, input logic t,
                     input logic [31:0] tgt, input logic mp);
    upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tgt; upd_mispred = mp;
  endtask

  task automatic idle();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btb_en = 1'b1; btb_clear = 1'b0; if_pc = 32'h100;
    idle();
    tick();
    rst = 1'b0;
    // 1: reset state
    chk("reset", 1'b0, 32'h104);
    tick();

    // 2: allocate; same-cycle lookup must not see the update
    upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    chk("alloc_same_cycle", 1'b0, 32'h104);
    tick();
    idle();
    chk("alloc_hit", 1'b1, 32'h200);
    tick();
    if_pc = 32'h102;
    chk("alloc_hit_lsbs_ignored", 1'b1, 32'h200);
    tick();
    if_pc = 32'h100;

    // 3: counter walk down with bottom saturation, then back up with top saturation
    upd(1'b1, 32'h100, 1'b0, 32'h999, 1'b0);
    chk("nt1_pre", 1'b1, 32'h200);
    tick();
    chk("ctr_01", 1'b0, 32'h200);
    tick();
    chk("ctr_00", 1'b0, 32'h200);
    tick();
    upd(1'b1, 32'h100, 1'b1, 32'h280, 1'b0);
    chk("ctr_00_sat", 1'b0, 32'h200);
    tick();
    chk("taken_from_00_ctr_01", 1'b0, 32'h280);
    tick();
    chk("ctr_10", 1'b1, 32'h280);
    tick();
    chk("ctr_11", 1'b1, 32'h280);
    tick();
    upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    chk("ctr_11_sat", 1'b1, 32'h280);
    tick();
    idle();
    chk("nt_from_11_ctr_10", 1'b1, 32'h280);
    tick();

    // 4: aliasing at idx 0
    upd(1'b1, 32'h140, 1'b1, 32'h300, 1'b0);
    chk("alias_pre", 1'b1, 32'h280);
    tick();
    idle();
    chk("alias_evicted", 1'b0, 32'h104);
    tick();
    if_pc = 32'h140;
    upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    chk("alias_new_hit", 1'b1, 32'h300);
    tick();
    idle();
    chk("miss_nt_no_change", 1'b1, 32'h300);
    tick();
    upd(1'b1, 32'h1004, 1'b1, 32'h2000, 1'b0);
    if_pc = 32'hFFFF_FFFC;
    chk("wrap_seq_pc", 1'b0, 32'h0000_0000);
    tick();
    idle();
    if_pc = 32'h1004;
    chk("idx1_hit", 1'b1, 32'h2000);
    tick();
    if_pc = 32'h1008;
    chk("idx2_miss", 1'b0, 32'h100C);
    tick();

    // 5: clear beats a simultaneous update
    upd(1'b1, 32'h1008, 1'b1, 32'h3000, 1'b0);
    btb_clear = 1'b1;
    tick();
    btb_clear = 1'b0;
    idle();
    chk("clear_drops_update", 1'b0, 32'h100C);
    tick();
    if_pc = 32'h140;
    upd(1'b1, 32'h140, 1'b0, 32'h0, 1'b0);
    chk("clear_invalidates", 1'b0, 32'h144);
    tick();
    upd(1'b1, 32'h140, 1'b1, 32'h500, 1'b0);
    chk("stale_not_used", 1'b0, 32'h144);
    tick();
    idle();
    chk("realloc", 1'b1, 32'h500);
    tick();

    // 6: prediction disable freezes lookup_cnt; target still reported
    btb_en = 1'b0;
    chk("en0_a", 1'b0, 32'h500);
    tick();
    chk("en0_b", 1'b0, 32'h500);
    tick();
    btb_en = 1'b1;

    // Mid-operation reset, then mispredict counter wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst", 1'b0, 32'h144);
    upd(1'b0, 32'h2000, 1'b0, 32'h0, 1'b1);
    tick();
    chk("mispred_needs_valid", 1'b0, 32'h144);
    for (int i = 0; i < 15; i++) begin
      upd(1'b1, 32'h2000, 1'b0, 32'h0, 1'b1);
      tick();
    end
    idle();
    chk("mispred_15", 1'b0, 32'h144);
    upd(1'b1, 32'h2000, 1'b0, 32'h0, 1'b1);
    tick();
    idle();
    chk("mispred_wrap_0", 1'b0, 32'h144);
    tick();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
